// File: rtl/lighthouse_pkg.sv
// lighthouse_pkg: shared word layout, frame constants, FSM state type and word packer.
package lighthouse_pkg;
  localparam int DURATION_W = 24;
  localparam int WORDS_PER_FRAME = 8;
  localparam int CH_HI = 31;
  localparam int CH_LO = 27;
  localparam int LH_BIT = 26;
  localparam int AXIS_BIT = 25;
  localparam int VALID_BIT = 24;
  typedef enum logic {IDLE, WAIT} frame_state_t;
  function automatic logic [31:0] pack_word(logic [CH_HI-CH_LO:0] ch, logic lh, logic ax,
                                            logic [DURATION_W-1:0] dur);
    logic [31:0] w;
    w = '0;
    w[CH_HI:CH_LO] = ch;
    w[LH_BIT] = lh;
    w[AXIS_BIT] = ax;
    w[VALID_BIT] = 1'b1;
    w[DURATION_W-1:0] = dur;
    return w;
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin arbiter, search starts one above the last granted index.
// Ports: clock, reset_n (async, active-low); req request vector; en allows a grant;
//        grant one-hot; idx granted index; any a grant is issued this cycle.
module rr_arbiter #(
  parameter int N = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic [N-1:0]  req,
  input  logic          en,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);
  logic [IW-1:0] last;
  always_comb begin
    any = 1'b0;
    idx = '0;
    for (int i = 1; i <= N; i++) begin
      if (!any && en && req[(int'(last) + i) % N]) begin
        any = 1'b1;
        idx = IW'((int'(last) + i) % N);
      end
    end
    grant = any ? (N'(1) << idx) : '0;
  end
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) last <= IW'(N - 1);
    else if (any) last <= idx;
endmodule

// File: rtl/lighthouse_frame_packer.sv
// lighthouse_frame_packer: packs per-channel sweep measurements into FIFO words and requests SPI frames.
// Ports: clock, reset_n (async, active-low); sensor_valid/duration/lighthouse/axis per channel;
//        fifo_full, fifo_content, fifo_read from the word FIFO and SPI stage;
//        fifo_wrreq/fifo_data FIFO write; send frame request pulse; overrun_count lost measurements.
module lighthouse_frame_packer
  import lighthouse_pkg::*;
#(
  parameter int NUM_SENSORS = 4,
  parameter int FIFO_DEPTH = 256,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic [NUM_SENSORS-1:0]    sensor_valid,
  input  logic [24*NUM_SENSORS-1:0] sensor_duration,
  input  logic [NUM_SENSORS-1:0]    sensor_lighthouse,
  input  logic [NUM_SENSORS-1:0]    sensor_axis,
  input  logic                      fifo_full,
  input  logic [8:0]                fifo_content,
  input  logic                      fifo_read,
  output logic                      fifo_wrreq,
  output logic [31:0]               fifo_data,
  output logic                      send,
  output logic [7:0]                overrun_count
);
  localparam int IW = (NUM_SENSORS > 1) ? $clog2(NUM_SENSORS) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [NUM_SENSORS-1:0] pending, grant;
  logic [31:0] holding [NUM_SENSORS];
  logic [IW-1:0] idx;
  logic any, en;
  logic [5:0] ovr_n;
  logic [8:0] ovr_sum;
  frame_state_t state;
  logic [3:0] rd_cnt;
  logic [TW-1:0] to_cnt;
  // a word count at or beyond capacity is treated like fifo_full
  assign en = !fifo_full && int'(fifo_content) < FIFO_DEPTH;
  rr_arbiter #(.N(NUM_SENSORS), .IW(IW)) u_arb (
    .clock(clock), .reset_n(reset_n), .req(pending), .en(en),
    .grant(grant), .idx(idx), .any(any)
  );
  // a measurement is lost only when a still-pending word is overwritten without being granted
  always_comb begin
    ovr_n = '0;
    for (int i = 0; i < NUM_SENSORS; i++) ovr_n += 6'(sensor_valid[i] & pending[i] & ~grant[i]);
    ovr_sum = {1'b0, overrun_count} + 9'(ovr_n);
  end
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      pending <= '0;
      for (int i = 0; i < NUM_SENSORS; i++) holding[i] <= '0;
      fifo_wrreq <= 1'b0;
      fifo_data <= '0;
      overrun_count <= '0;
    end else begin
      // granted word leaves from the old holding value; a coincident valid reloads and stays pending
      for (int i = 0; i < NUM_SENSORS; i++) begin
        pending[i] <= sensor_valid[i] | (pending[i] & ~grant[i]);
        if (sensor_valid[i])
          holding[i] <= pack_word(5'(i), sensor_lighthouse[i], sensor_axis[i],
                                  sensor_duration[24*i +: DURATION_W]);
      end
      fifo_wrreq <= any;
      if (any) fifo_data <= holding[idx];
      overrun_count <= (ovr_sum > 9'd255) ? 8'hFF : ovr_sum[7:0];
    end
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      send <= 1'b0;
      rd_cnt <= '0;
      to_cnt <= '0;
    end else begin
      send <= 1'b0;
      if (state == IDLE) begin
        if (fifo_content >= 9'(WORDS_PER_FRAME)) begin
          send <= 1'b1;
          state <= WAIT;
          rd_cnt <= '0;
          to_cnt <= '0;
        end
      end else begin
        rd_cnt <= rd_cnt + 4'(fifo_read);
        to_cnt <= to_cnt + TW'(1);
        if ((fifo_read && rd_cnt == 4'(WORDS_PER_FRAME - 1)) || to_cnt == TW'(TIMEOUT_CYCLES - 1))
          state <= IDLE;
      end
    end
endmodule

// File: tb/tb_lighthouse_frame_packer.sv
// tb_lighthouse_frame_packer: directed scoreboard bench for lighthouse_frame_packer.
module tb_lighthouse_frame_packer;
  localparam int NS = 4;
  logic clock = 1'b0;
  logic reset_n;
  logic [NS-1:0] sensor_valid, sensor_lighthouse, sensor_axis;
  logic [24*NS-1:0] sensor_duration;
  logic fifo_full, fifo_read;
  logic [8:0] fifo_content;
  logic fifo_wrreq, send;
  logic [31:0] fifo_data;
  logic [7:0] overrun_count;
  int checks = 0, errors = 0;
  int cyc = 0, send_cnt = 0, send_cyc = 0;
  logic [31:0] q[$];

  lighthouse_frame_packer #(.NUM_SENSORS(NS), .FIFO_DEPTH(256), .TIMEOUT_CYCLES(100)) dut (
    .clock(clock), .reset_n(reset_n), .sensor_valid(sensor_valid),
    .sensor_duration(sensor_duration), .sensor_lighthouse(sensor_lighthouse),
    .sensor_axis(sensor_axis), .fifo_full(fifo_full), .fifo_content(fifo_content),
    .fifo_read(fifo_read), .fifo_wrreq(fifo_wrreq), .fifo_data(fifo_data),
    .send(send), .overrun_count(overrun_count)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    cyc++;
    if (send) begin
      send_cnt++;
      send_cyc = cyc;
    end
    if (fifo_wrreq) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got %h, required no write", fifo_data);
      end else begin
        logic [31:0] e;
        e = q.pop_front();
        if (fifo_data !== e) begin
          errors++;
          $display("FAIL write_data: got %h, required %h", fifo_data, e);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    sensor_valid = '0; sensor_lighthouse = '0; sensor_axis = '0; sensor_duration = '0;
    fifo_full = 1'b0; fifo_read = 1'b0; fifo_content = '0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
  endtask

  task automatic set_ch(input int ch, input logic [23:0] d, input logic lh, input logic ax);
    sensor_valid[ch] = 1'b1;
    sensor_duration[24*ch +: 24] = d;
    sensor_lighthouse[ch] = lh;
    sensor_axis[ch] = ax;
  endtask

  task automatic wait_sends(input int target, input int budget, input string name);
    int n = 0;
    while (send_cnt < target && n < budget) begin
      @(negedge clock);
      n++;
    end
    if (send_cnt < target) chk(name, 32'(send_cnt), 32'(target));
  endtask

  initial begin
    int base, t0;
    #200000;
    $display("FAIL watchdog: simulation did not complete, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, t0;
    // reset state and single-channel latency
    do_reset();
    chk("rst_wrreq", 32'(fifo_wrreq), 0);
    chk("rst_data", fifo_data, 0);
    chk("rst_send", 32'(send), 0);
    chk("rst_overrun", 32'(overrun_count), 0);
    set_ch(2, 24'h00ABCD, 1'b1, 1'b0);
    q.push_back(32'h1500ABCD);
    @(negedge clock);
    sensor_valid = '0;
    chk("lat_early", 32'(fifo_wrreq), 0);
    @(negedge clock);
    chk("lat_write", 32'(fifo_wrreq), 1);
    repeat (3) @(negedge clock);
    chk("single_drained", 32'(q.size()), 0);

    // all four channels at once, then channels 0 and 3
    do_reset();
    set_ch(0, 24'h100000, 1'b0, 1'b0);
    set_ch(1, 24'h100001, 1'b1, 1'b0);
    set_ch(2, 24'h100002, 1'b0, 1'b1);
    set_ch(3, 24'h100003, 1'b1, 1'b1);
    q.push_back(32'h01100000);
    q.push_back(32'h0D100001);
    q.push_back(32'h13100002);
    q.push_back(32'h1F100003);
    @(negedge clock);
    sensor_valid = '0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      chk("burst_wrreq", 32'(fifo_wrreq), 1);
    end
    repeat (2) @(negedge clock);
    chk("burst_drained", 32'(q.size()), 0);
    set_ch(0, 24'h0000AA, 1'b1, 1'b1);
    set_ch(3, 24'h0000BB, 1'b0, 1'b0);
    q.push_back(32'h070000AA);
    q.push_back(32'h190000BB);
    @(negedge clock);
    sensor_valid = '0;
    repeat (5) @(negedge clock);
    chk("pair_drained", 32'(q.size()), 0);

    // fifo_full backpressure with overruns
    do_reset();
    fifo_full = 1'b1;
    for (int c = 0; c < 10; c++) begin
      sensor_valid = '0;
      if (c == 1 || c == 4 || c == 7) set_ch(1, 24'h000100 + 24'(c), 1'b0, 1'b1);
      @(negedge clock);
    end
    sensor_valid = '0;
    chk("full_overrun", 32'(overrun_count), 2);
    q.push_back(32'h0B000107);
    fifo_full = 1'b0;
    repeat (3) @(negedge clock);
    chk("full_drained", 32'(q.size()), 0);

    // overrun saturation
    do_reset();
    fifo_full = 1'b1;
    set_ch(0, 24'h00FFFF, 1'b1, 1'b1);
    repeat (300) @(negedge clock);
    sensor_valid = '0;
    @(negedge clock);
    chk("overrun_sat", 32'(overrun_count), 255);
    q.push_back(32'h0700FFFF);
    fifo_full = 1'b0;
    repeat (3) @(negedge clock);
    chk("sat_drained", 32'(q.size()), 0);

    // frame request and 8-read completion
    do_reset();
    base = send_cnt;
    fifo_content = 9'd7;
    repeat (5) @(negedge clock);
    chk("send_below8", 32'(send_cnt - base), 0);
    fifo_content = 9'd8;
    repeat (3) @(negedge clock);
    chk("send_first", 32'(send_cnt - base), 1);
    repeat (5) @(negedge clock);
    chk("send_wait_hold", 32'(send_cnt - base), 1);
    for (int i = 0; i < 7; i++) begin
      fifo_read = 1'b1;
      @(negedge clock);
      fifo_read = 1'b0;
      @(negedge clock);
    end
    repeat (3) @(negedge clock);
    chk("send_after7", 32'(send_cnt - base), 1);
    fifo_read = 1'b1;
    @(negedge clock);
    fifo_read = 1'b0;
    repeat (3) @(negedge clock);
    chk("send_after8", 32'(send_cnt - base), 2);
    fifo_content = 9'd0;

    // WAIT timeout
    do_reset();
    base = send_cnt;
    fifo_content = 9'd8;
    wait_sends(base + 1, 20, "timeout_first_send");
    t0 = send_cyc;
    for (int i = 0; i < 3; i++) begin
      fifo_read = 1'b1;
      @(negedge clock);
      fifo_read = 1'b0;
      @(negedge clock);
    end
    wait_sends(base + 2, 300, "timeout_second_send");
    chk("timeout_gap", 32'(send_cyc - t0), 101);
    fifo_content = 9'd0;

    // reset during WAIT with pending channels
    do_reset();
    set_ch(3, 24'h00C0DE, 1'b0, 1'b0);
    q.push_back(32'h1900C0DE);
    @(negedge clock);
    sensor_valid = '0;
    fifo_content = 9'd8;
    repeat (3) @(negedge clock);
    fifo_full = 1'b1;
    set_ch(0, 24'h000011, 1'b1, 1'b0);
    set_ch(1, 24'h000022, 1'b0, 1'b1);
    @(negedge clock);
    sensor_valid = '0;
    set_ch(0, 24'h000033, 1'b1, 1'b0);
    @(negedge clock);
    sensor_valid = '0;
    chk("pre_rst_overrun", 32'(overrun_count), 1);
    #2 reset_n = 1'b0;
    #1;
    chk("midrst_wrreq", 32'(fifo_wrreq), 0);
    chk("midrst_data", fifo_data, 0);
    chk("midrst_send", 32'(send), 0);
    chk("midrst_overrun", 32'(overrun_count), 0);
    fifo_full = 1'b0;
    fifo_content = 9'd0;
    @(negedge clock);
    base = send_cnt;
    reset_n = 1'b1;
    repeat (10) @(negedge clock);
    chk("midrst_no_send", 32'(send_cnt - base), 0);
    chk("midrst_drained", 32'(q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/lighthouse_frame_packer.md
LIGHTHOUSE_FRAME_PACKER -- requirements
Module: lighthouse_frame_packer

Interface
REQ-001 Parameter NUM_SENSORS, default 4, number of lighthouse sensor channels (1..32).
REQ-002 Parameter FIFO_DEPTH, default 256, capacity in words of the external word FIFO.
REQ-003 Parameter TIMEOUT_CYCLES, default 65535, maximum WAIT dwell before forced return to IDLE.
REQ-004 clock  input  1  rising-edge system clock.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 sensor_valid  input  NUM_SENSORS  one-cycle pulse per channel: new sweep measurement.
REQ-007 sensor_duration  input  24*NUM_SENSORS  sweep duration per channel, channel i in bits [24i+23:24i].
REQ-008 sensor_lighthouse  input  NUM_SENSORS  lighthouse id per channel, sampled with sensor_valid.
REQ-009 sensor_axis  input  NUM_SENSORS  sweep axis per channel, sampled with sensor_valid.
REQ-010 fifo_full  input  1  external FIFO cannot accept a write.
REQ-011 fifo_content  input  9  external FIFO word count.
REQ-012 fifo_read  input  1  downstream SPI stage pops one word (monitored only).
REQ-013 fifo_wrreq  output  1  one-cycle FIFO write strobe.
REQ-014 fifo_data  output  32  packed word.
REQ-015 send  output  1  one-cycle pulse requesting an 8-word SPI frame.
REQ-016 overrun_count  output  8  saturating count of lost measurements.

Function
REQ-017 Word format SHALL be [31:27] channel index, [26] lighthouse, [25] axis, [24] 1 (valid), [23:0] duration.
REQ-018 Each channel SHALL hold one holding register and a pending flag; sensor_valid at edge k loads holding and sets pending at edge k.
REQ-019 A round-robin arbiter SHALL grant one pending channel per cycle when fifo_full=0, starting the search one above the last granted index and wrapping.
REQ-020 On grant at edge k+1, fifo_wrreq=1 and fifo_data=granted word SHALL be registered; the grant clears pending unless REQ-021 applies.
REQ-021 If a channel's sensor_valid coincides with its grant, the old word SHALL be written, holding reloads with the new value, pending stays 1, no overrun.
REQ-022 If sensor_valid arrives while pending=1 and not granted, holding SHALL be overwritten and overrun_count incremented, saturating at 255.
REQ-023 fifo_full=1 SHALL suppress grants and fifo_wrreq; pending flags persist.
REQ-024 Frame FSM states IDLE, WAIT: IDLE with fifo_content>=8 SHALL pulse send for one cycle and enter WAIT.
REQ-025 WAIT SHALL count fifo_read pulses (4-bit); on the 8th it returns to IDLE; send stays 0 in WAIT.
REQ-026 WAIT SHALL also return to IDLE after TIMEOUT_CYCLES cycles without completing 8 reads; read and timeout counters clear on entry to WAIT.
REQ-027 After return to IDLE, send SHALL not re-pulse earlier than the next cycle.

Reset
REQ-028 Reset SHALL clear pending, holding registers, arbiter pointer (last=NUM_SENSORS-1), fifo_wrreq, fifo_data, send, overrun_count, counters; FSM to IDLE.
REQ-029 Reset mid-frame SHALL abandon WAIT without a send pulse; pending measurements are discarded.

Structure
REQ-030 Package lighthouse_pkg SHALL hold word field positions, WORDS_PER_FRAME=8, DURATION_W=24.
REQ-031 The round-robin arbiter SHALL be the sub-module rr_arbiter (request vector, enable, grant one-hot, pointer update).

Verification
REQ-032 Channel 2 valid, duration 0x00ABCD, lighthouse 1, axis 0 -> one fifo_wrreq two edges later, fifo_data=0x15 00ABCD (0x1500ABCD).
REQ-033 Channels 0..3 valid same cycle -> four consecutive writes in order 0,1,2,3; then channels 0,3 -> order 0,3.
REQ-034 fifo_full held 10 cycles with channel 1 valid pulsed 3 times -> no writes, overrun_count=2, one write of last value after release.
REQ-035 fifo_content steps 7->8 -> single send pulse; 8 fifo_read pulses -> IDLE; with content still >=8, second send pulse.
REQ-036 TIMEOUT_CYCLES=100, send then only 3 fifo_read -> IDLE after 100 cycles, new send pulse.
REQ-037 Reset asserted in WAIT with 2 channels pending -> all outputs 0 immediately, no writes after release.
